memaccess_unit: RTL and testbench

//  Parametrised memory-access stage: takes one load/store request at a time and sequences the data-memory bus.

---
 rtl/memaccess_unit_pkg.sv | 19 +
 rtl/memaccess_unit.sv | 109 ++++++++++
 tb/tb_memaccess_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/memaccess_unit_pkg.sv
// memaccess_unit_pkg: shared op and state encodings for the memory-access stage
package memaccess_unit_pkg;

  typedef enum logic [1:0] {
    LOAD      = 2'b00,
    STORE     = 2'b01,
    LOAD_IND  = 2'b10,
    STORE_IND = 2'b11
  } memacc_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    PTR  = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } memacc_state_e;

endpackage

// File: rtl/memaccess_unit.sv
// memaccess_unit: sequences one load/store (direct or pointer-indirect) onto the data-memory bus
module memaccess_unit
  import memaccess_unit_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1,
  parameter int IND_EN  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] DMem_addr,
  output logic [DATA_W-1:0] DMem_din,
  output logic              DMem_rd,
  output logic              DMem_we,
  input  logic [DATA_W-1:0] DMem_dout,
  output logic [DATA_W-1:0] memout,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  memacc_state_e     state_q, state_d;
  memacc_op_e        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] memout_q, memout_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              accept, reject;

  assign req_ready = reset && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign reject    = req_op[1] && (IND_EN == 0);

  assign DMem_addr = addr_q;
  assign DMem_din  = (state_q == WR) ? wdata_q : '0;
  assign DMem_rd   = (state_q == RD) || (state_q == PTR);
  assign DMem_we   = (state_q == WR);
  assign memout    = memout_q;
  assign done      = (state_q == FIN);
  assign err       = done && err_q;

  // next-state: accept a request, count read latency, chase the pointer, then finish
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    memout_d = memout_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d    = memacc_op_e'(req_op);
        wdata_d = req_wdata;
        cnt_d   = CNT_INIT;
        err_d   = reject;
        addr_d  = reject ? addr_q : req_addr;
        state_d = reject ? FIN : (req_op[1] ? PTR : (req_op[0] ? WR : RD));
      end
      RD: begin
        memout_d = (cnt_q == '0) ? DMem_dout : memout_q;
        state_d  = (cnt_q == '0) ? FIN : RD;
        cnt_d    = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      end
      PTR: begin
        addr_d  = (cnt_q == '0) ? ADDR_W'(DMem_dout) : addr_q;
        state_d = (cnt_q != '0) ? PTR : ((op_q == LOAD_IND) ? RD : WR);
        cnt_d   = (cnt_q == '0) ? CNT_INIT : cnt_q - 1'b1;
      end
      WR:  state_d = FIN;
      FIN: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers; an active-low reset aborts any op in flight
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= LOAD;
      addr_q   <= '0;
      wdata_q  <= '0;
      memout_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      memout_q <= memout_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_memaccess_unit.sv
// tb_memaccess_unit: directed checks of the memory-access stage at MEM_LAT=2, MEM_LAT=1 and IND_EN=0
module tb_memaccess_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic [15:0] dm_addr, dm_din, dm_dout, memout;
  logic        dm_rd, dm_we, done, err;

  logic        v1 = 1'b0, rdy1, rd1, we1, done1, err1;
  logic [15:0] a1 = '0, wd1 = '0, dma1, dmd1, dmo1, mo1;
  logic        v2 = 1'b0, rdy2, rd2, we2, done2, err2;
  logic [1:0]  op2 = 2'b10;
  logic [15:0] a2 = '0, wd2 = '0, dma2, dmd2, dmo2, mo2;

  logic [15:0] mem [0:65535];
  logic        wv  [0:65535];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return (a == 16'h3000) ? 16'hBEEF : (a == 16'h3020) ? 16'h4000 :
           (a == 16'h4000) ? 16'h00AA : (a == 16'h3030) ? 16'h5000 : 16'h0000;
  endfunction

  function automatic logic [15:0] rdmem(input logic [15:0] a);
    return (wv[a] === 1'b1) ? mem[a] : rom(a);
  endfunction

  assign dm_dout = rdmem(dm_addr);
  assign dmo1    = rdmem(dma1);
  assign dmo2    = rdmem(dma2);

  always @(posedge clock) if (dm_we) begin
    mem[dm_addr] <= dm_din;
    wv[dm_addr]  <= 1'b1;
  end

  memaccess_unit #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .IND_EN(1)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .DMem_addr(dm_addr), .DMem_din(dm_din), .DMem_rd(dm_rd),
    .DMem_we(dm_we), .DMem_dout(dm_dout), .memout(memout), .done(done), .err(err));

  memaccess_unit #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .IND_EN(1)) dut_lat1 (
    .clock(clock), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_op(2'b00),
    .req_addr(a1), .req_wdata(wd1), .DMem_addr(dma1), .DMem_din(dmd1), .DMem_rd(rd1),
    .DMem_we(we1), .DMem_dout(dmo1), .memout(mo1), .done(done1), .err(err1));

  memaccess_unit #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .IND_EN(0)) dut_noind (
    .clock(clock), .reset(reset), .req_valid(v2), .req_ready(rdy2), .req_op(op2),
    .req_addr(a2), .req_wdata(wd2), .DMem_addr(dma2), .DMem_din(dmd2), .DMem_rd(rd2),
    .DMem_we(we2), .DMem_dout(dmo2), .memout(mo2), .done(done2), .err(err2));

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Issue one request on the main unit and observe the bus until done (bounded); ends in the done cycle.
  task automatic issue(input logic [1:0] op, input logic [15:0] a, wd, output int lat, nrd, nwe,
                       output logic [15:0] rda, rdb, wa, wdv, output logic e, both);
    lat = 0; nrd = 0; nwe = 0; rda = '0; rdb = '0; wa = '0; wdv = '0; e = 1'b0; both = 1'b0;
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    tick;
    req_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (dm_rd) begin
        if (nrd == 0) rda = dm_addr;
        rdb = dm_addr;
        nrd++;
      end
      if (dm_we) begin
        wa = dm_addr; wdv = dm_din; nwe++;
      end
      if (dm_rd && dm_we) both = 1'b1;
      if (done) begin
        lat = i; e = err;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    int seen;
    req_valid = 1'b1; req_op = 2'b00; req_addr = 16'h3000;
    repeat (3) tick;
    n_chk++; if ({dm_rd, dm_we, done, err} !== 4'b0) begin n_fail++; $display("FAIL rst_strobes got %b exp 0000", {dm_rd, dm_we, done, err}); end
    n_chk++; if (memout !== 16'h0 || dm_addr !== 16'h0 || dm_din !== 16'h0) begin n_fail++; $display("FAIL rst_data got memout=%h addr=%h din=%h exp 0", memout, dm_addr, dm_din); end
    n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_low got %b exp 0", req_ready); end
    req_valid = 1'b0; reset = 1'b1;
    tick;
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got %b exp 1", req_ready); end
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    n_chk++; if (dm_rd !== 1'b1) begin n_fail++; $display("FAIL abort_started got rd=%b exp 1", dm_rd); end
    reset = 1'b0;
    tick;
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || dm_rd || dm_we) seen++;
      tick;
    end
    n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL abort_quiet got %0d active cycles exp 0", seen); end
    n_chk++; if (memout !== 16'h0) begin n_fail++; $display("FAIL abort_memout got %h exp 0000", memout); end
  endtask

  task automatic test_load;
    int lat, nrd, nwe; logic [15:0] ra, rb, wa, wdv; logic e, both;
    issue(2'b00, 16'h3000, 16'h0, lat, nrd, nwe, ra, rb, wa, wdv, e, both);
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL load_lat got %0d exp 3", lat); end
    n_chk++; if (nrd !== 2 || nwe !== 0) begin n_fail++; $display("FAIL load_strobes got rd=%0d we=%0d exp 2 0", nrd, nwe); end
    n_chk++; if (ra !== 16'h3000 || rb !== 16'h3000) begin n_fail++; $display("FAIL load_addr got %h %h exp 3000 3000", ra, rb); end
    n_chk++; if (memout !== 16'hBEEF || e !== 1'b0) begin n_fail++; $display("FAIL load_data got %h err=%b exp beef 0", memout, e); end
    tick;
    n_chk++; if (done !== 1'b0 || req_ready !== 1'b1 || dm_addr !== 16'h3000) begin n_fail++; $display("FAIL load_idle got done=%b rdy=%b addr=%h exp 0 1 3000", done, req_ready, dm_addr); end
  endtask

  task automatic test_store;
    int lat, nrd, nwe; logic [15:0] ra, rb, wa, wdv; logic e, both;
    issue(2'b01, 16'h3010, 16'h1234, lat, nrd, nwe, ra, rb, wa, wdv, e, both);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL store_lat got %0d exp 2", lat); end
    n_chk++; if (nwe !== 1 || nrd !== 0 || wa !== 16'h3010 || wdv !== 16'h1234) begin n_fail++; $display("FAIL store_bus got we=%0d rd=%0d a=%h d=%h exp 1 0 3010 1234", nwe, nrd, wa, wdv); end
    n_chk++; if (memout !== 16'hBEEF || dm_din !== 16'h0) begin n_fail++; $display("FAIL store_hold got memout=%h din=%h exp beef 0000", memout, dm_din); end
    tick;
    n_chk++; if (mem[16'h3010] !== 16'h1234) begin n_fail++; $display("FAIL store_mem got %h exp 1234", mem[16'h3010]); end
  endtask

  task automatic test_indirect;
    int lat, nrd, nwe; logic [15:0] ra, rb, wa, wdv; logic e, both;
    issue(2'b10, 16'h3020, 16'h0, lat, nrd, nwe, ra, rb, wa, wdv, e, both);
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL ldind_lat got %0d exp 5", lat); end
    n_chk++; if (nrd !== 4 || ra !== 16'h3020 || rb !== 16'h4000) begin n_fail++; $display("FAIL ldind_bus got n=%0d %h %h exp 4 3020 4000", nrd, ra, rb); end
    n_chk++; if (memout !== 16'h00AA || e !== 1'b0) begin n_fail++; $display("FAIL ldind_data got %h err=%b exp 00aa 0", memout, e); end
    tick;
    issue(2'b11, 16'h3030, 16'h0055, lat, nrd, nwe, ra, rb, wa, wdv, e, both);
    n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL stind_lat got %0d exp 4", lat); end
    n_chk++; if (nrd !== 2 || ra !== 16'h3030 || nwe !== 1 || wa !== 16'h5000 || wdv !== 16'h0055) begin n_fail++; $display("FAIL stind_bus got rd=%0d %h we=%0d %h %h exp 2 3030 1 5000 0055", nrd, ra, nwe, wa, wdv); end
    n_chk++; if (memout !== 16'h00AA || both !== 1'b0) begin n_fail++; $display("FAIL stind_hold got memout=%h both=%b exp 00aa 0", memout, both); end
    tick;
    n_chk++; if (mem[16'h5000] !== 16'h0055) begin n_fail++; $display("FAIL stind_mem got %h exp 0055", mem[16'h5000]); end
  endtask

  task automatic test_no_indirect;
    int lat, act;
    lat = 0; act = 0;
    v2 = 1'b1; op2 = 2'b11; a2 = 16'h3030; wd2 = 16'h0077;
    tick;
    v2 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (rd2 || we2) act++;
      if (done2) begin
        lat = i;
        break;
      end
      tick;
    end
    n_chk++; if (lat !== 1 || err2 !== 1'b1) begin n_fail++; $display("FAIL noind_done got lat=%0d err=%b exp 1 1", lat, err2); end
    n_chk++; if (act !== 0 || dma2 !== 16'h0) begin n_fail++; $display("FAIL noind_bus got %0d strobes addr=%h exp 0 0000", act, dma2); end
    tick;
    n_chk++; if (err2 !== 1'b0 || done2 !== 1'b0 || rdy2 !== 1'b1) begin n_fail++; $display("FAIL noind_after got err=%b done=%b rdy=%b exp 0 0 1", err2, done2, rdy2); end
  endtask

  task automatic test_back_to_back;
    int lat;
    lat = 0;
    req_valid = 1'b1; req_op = 2'b00; req_addr = 16'h3000;
    tick;
    for (int i = 1; i <= 10; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      tick;
    end
    n_chk++; if (lat !== 3 || req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_first got lat=%0d rdy=%b exp 3 0", lat, req_ready); end
    tick;
    n_chk++; if (req_ready !== 1'b1 || dm_rd !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got rdy=%b rd=%b exp 1 0", req_ready, dm_rd); end
    tick;
    req_addr = 16'h3010; req_op = 2'b01; req_wdata = 16'hDEAD;
    n_chk++; if (dm_rd !== 1'b1 || dm_addr !== 16'h3000 || req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second got rd=%b addr=%h rdy=%b exp 1 3000 0", dm_rd, dm_addr, req_ready); end
    tick;
    n_chk++; if (dm_addr !== 16'h3000 || dm_we !== 1'b0) begin n_fail++; $display("FAIL b2b_busy got addr=%h we=%b exp 3000 0", dm_addr, dm_we); end
    req_valid = 1'b0;
    tick;
    n_chk++; if (done !== 1'b1 || memout !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_done got done=%b memout=%h exp 1 beef", done, memout); end
    tick;
  endtask

  task automatic test_lat1;
    int lat, nrd;
    lat = 0; nrd = 0;
    v1 = 1'b1; a1 = 16'h3000;
    tick;
    v1 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (rd1) nrd++;
      if (done1) begin
        lat = i;
        break;
      end
      tick;
    end
    n_chk++; if (lat !== 2 || nrd !== 1) begin n_fail++; $display("FAIL lat1_load got lat=%0d rd=%0d exp 2 1", lat, nrd); end
    n_chk++; if (mo1 !== 16'hBEEF || err1 !== 1'b0) begin n_fail++; $display("FAIL lat1_data got %h err=%b exp beef 0", mo1, err1); end
    tick;
  endtask

  initial begin
    tick;
    test_reset;
    test_load;
    test_store;
    test_indirect;
    test_no_indirect;
    test_back_to_back;
    test_lat1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
